// File: rtl/multi_channel_valid_delay_line.sv
// Per-channel circular-buffer delay line: each accepted sample re-emerges exactly depth valid transfers later.
// Latency: combinational output (0 cycles); 1 cycle when MC_DELAY_LINE_REG_OUT_EN is defined.
// Backpressure: none; every in_valid beat is accepted unless flush is high (flush drops the beat).
// Optional feature macro: MC_DELAY_LINE_REG_OUT_EN (registered outputs).
module multi_channel_valid_delay_line #(
  parameter int width      = 8,
  parameter int depth      = 8,
  parameter int n_channels = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [n_channels-1:0]         in_valid,
  input  logic [n_channels*width-1:0]   in_data,
  output logic [n_channels-1:0]         out_valid,
  output logic [n_channels*width-1:0]   out_data
);

  // Pointer is just wide enough to index depth entries; wrap is explicit so
  // non-power-of-2 depths never visit the unused codes.
  localparam int              PW   = $clog2(depth);
  localparam logic [PW-1:0]   LAST = PW'(depth - 1);

  // A beat is a real transfer only when flush is low; flush swallows it.
  logic [n_channels-1:0]       xfer;
  logic [n_channels-1:0]       comb_valid;
  logic [n_channels*width-1:0] comb_data;

  assign xfer = in_valid & ~{n_channels{flush}};

  for (genvar c = 0; c < n_channels; c++) begin : g_chan
    logic [PW-1:0]    ptr;
    logic [depth-1:0] vbit;
    logic [width-1:0] mem [depth];

    // Pointer and occupancy: cleared by reset or flush, advance only on a transfer.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ptr  <= '0;
        vbit <= '0;
      end else if (flush) begin
        ptr  <= '0;
        vbit <= '0;
      end else if (xfer[c]) begin
        vbit[ptr] <= 1'b1;
        ptr       <= (ptr == LAST) ? '0 : ptr + 1'b1;
      end
    end

    // Sample storage is never reset; occupancy flags decide whether it is meaningful.
    always_ff @(posedge clk) begin
      if (xfer[c] && !rst) begin
        mem[ptr] <= in_data[c*width +: width];
      end
    end

    // Read the entry about to be overwritten: it was written depth transfers ago.
    assign comb_valid[c] = in_valid[c] & vbit[ptr] & ~flush & ~rst;
    assign comb_data[c*width +: width] = comb_valid[c] ? mem[ptr] : '0;
  end

`ifdef MC_DELAY_LINE_REG_OUT_EN
  // Registered outputs: load the combinational result every clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= comb_valid;
      out_data  <= comb_data;
    end
  end
`else
  assign out_valid = comb_valid;
  assign out_data  = comb_data;
`endif

endmodule
